// File: rtl/mem_wb_skid_if.sv
// ---------------------------------------------------------------------------
// mem_wb_skid_if
// Handshake bundle between MEM, the MEM->WB skid stage and WB.
//   in_*   : MEM -> stage request (valid/ready, addr, we, data)
//   out_*  : stage -> WB request (valid/ready, addr, we, data)
//   fwd_*  : bypass lookup, present only when MEM_WB_FWD_EN is defined
// Modports:
//   slave  : the pipeline stage itself
//   master : the surrounding pipeline (MEM producer, WB consumer, bypass user)
// ---------------------------------------------------------------------------
interface mem_wb_skid_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic              in_we;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic              out_we;
  logic [DATA_W-1:0] out_data;

`ifdef MEM_WB_FWD_EN
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  modport slave (
    input  in_valid, in_addr, in_we, in_data, out_ready, fwd_addr,
    output in_ready, out_valid, out_addr, out_we, out_data, fwd_hit, fwd_data
  );
  modport master (
    output in_valid, in_addr, in_we, in_data, out_ready, fwd_addr,
    input  in_ready, out_valid, out_addr, out_we, out_data, fwd_hit, fwd_data
  );
`else
  modport slave (
    input  in_valid, in_addr, in_we, in_data, out_ready,
    output in_ready, out_valid, out_addr, out_we, out_data
  );
  modport master (
    output in_valid, in_addr, in_we, in_data, out_ready,
    input  in_ready, out_valid, out_addr, out_we, out_data
  );
`endif
endinterface

// File: rtl/mem_wb_skid.sv
// ---------------------------------------------------------------------------
// mem_wb_skid
// MEM->WB pipeline stage built as a two-entry skid buffer. One register-file
// write request per entry; in_ready is taken straight from a state register so
// WB back-pressure never reaches MEM combinationally.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous reset, active-low
//   flush  : synchronous; drops both held entries and the current input
//   bus    : mem_wb_skid_if.slave (in_*, out_*, optional fwd_*)
// Optional feature macro: MEM_WB_FWD_EN adds a combinational bypass lookup
// (fwd_addr -> fwd_hit/fwd_data) over the held entries, youngest first.
// ---------------------------------------------------------------------------
module mem_wb_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  mem_wb_skid_if.slave       bus
);

  // Bit 1 alone marks FULL, so in_ready is a direct register bit.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_e;

  state_e            state_q, state_d;

  logic [ADDR_W-1:0] main_addr_q, main_addr_d;
  logic              main_we_q,   main_we_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic              skid_we_q,   skid_we_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic main_vld;
  logic skid_vld;
  logic in_ready;
  logic out_valid;
  logic in_fire;
  logic out_fire;

  assign in_fire  = bus.in_valid & in_ready;
  assign out_fire = out_valid & bus.out_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (in_fire) state_d = ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_d = FULL;
          else if (!in_fire && out_fire) state_d = EMPTY;
        end
        FULL:    if (out_fire) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output decode
  always_comb begin
    main_vld  = (state_q == ONE) || (state_q == FULL);
    skid_vld  = state_q[1];
    in_ready  = ~state_q[1];
    out_valid = main_vld;
  end

  // Entry payload next-state. Payload is left untouched on flush so the
  // outputs keep their last value; only the state clears.
  always_comb begin
    main_addr_d = main_addr_q;
    main_we_d   = main_we_q;
    main_data_d = main_data_q;
    skid_addr_d = skid_addr_q;
    skid_we_d   = skid_we_q;
    skid_data_d = skid_data_q;
    if (!flush) begin
      if (in_fire && (state_q == EMPTY || (state_q == ONE && out_fire))) begin
        main_addr_d = bus.in_addr;
        main_we_d   = bus.in_we;
        main_data_d = bus.in_data;
      end else if (state_q == FULL && out_fire) begin
        main_addr_d = skid_addr_q;
        main_we_d   = skid_we_q;
        main_data_d = skid_data_q;
      end
      if (in_fire && state_q == ONE && !out_fire) begin
        skid_addr_d = bus.in_addr;
        skid_we_d   = bus.in_we;
        skid_data_d = bus.in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_addr_q <= '0;
      main_we_q   <= 1'b0;
      main_data_q <= '0;
      skid_addr_q <= '0;
      skid_we_q   <= 1'b0;
      skid_data_q <= '0;
    end else begin
      main_addr_q <= main_addr_d;
      main_we_q   <= main_we_d;
      main_data_q <= main_data_d;
      skid_addr_q <= skid_addr_d;
      skid_we_q   <= skid_we_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_addr  = main_addr_q;
  assign bus.out_data  = main_data_q;
  // x0 and we=0 entries travel as valid bubbles with the write masked here
  assign bus.out_we    = main_we_q & out_valid & (main_addr_q != '0);

`ifdef MEM_WB_FWD_EN
  logic skid_hit;
  logic main_hit;

  // Skid holds the younger request, so it wins when both match
  always_comb begin
    skid_hit     = !flush && skid_vld && skid_we_q && (bus.fwd_addr != '0) &&
                   (skid_addr_q == bus.fwd_addr);
    main_hit     = !flush && main_vld && main_we_q && (bus.fwd_addr != '0) &&
                   (main_addr_q == bus.fwd_addr);
    bus.fwd_hit  = skid_hit | main_hit;
    bus.fwd_data = '0;
    if (skid_hit)      bus.fwd_data = skid_data_q;
    else if (main_hit) bus.fwd_data = main_data_q;
  end
`endif

endmodule

// File: tb/tb_mem_wb_skid.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_skid
// Directed bench for mem_wb_skid: reset, back-pressure, full-rate streaming,
// flush, x0 suppression and (with MEM_WB_FWD_EN) the bypass lookup.
// ---------------------------------------------------------------------------
module tb_mem_wb_skid;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  mem_wb_skid_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_wb_skid #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] a,
                       input logic we, input logic [DATA_W-1:0] d);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_we    = we;
    bus.in_data  = d;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd7, 1'b1, 32'h0000_1234);
    tick();
    drive(1'b1, 5'd8, 1'b1, 32'h0000_5678);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.out_we !== 1'b0) begin errors++; $display("FAIL rst_out_we got %0b want 0", bus.out_we); end
    checks++; if (bus.out_addr !== 5'd0) begin errors++; $display("FAIL rst_out_addr got %0d want 0", bus.out_addr); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h want 0", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    drive(1'b1, 5'd3, 1'b1, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %0b want 1", bus.out_valid); end
    checks++; if (bus.out_addr !== 5'd3) begin errors++; $display("FAIL first_addr got %0d want 3", bus.out_addr); end
    checks++; if (bus.out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL first_data got %h want deadbeef", bus.out_data); end
    checks++; if (bus.out_we !== 1'b1) begin errors++; $display("FAIL first_we got %0b want 1", bus.out_we); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL held_data got %h want deadbeef", bus.out_data); end
    checks++; if (bus.out_we !== 1'b0) begin errors++; $display("FAIL held_we got %0b want 0", bus.out_we); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 32'hA);
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_a got %0b want 1", bus.in_ready); end
    drive(1'b1, 5'd2, 1'b1, 32'hB);
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_b got %0b want 0", bus.in_ready); end
    checks++; if (bus.out_data !== 32'hA) begin errors++; $display("FAIL bp_stall_data got %h want a", bus.out_data); end
    // C waits while the stage is full
    drive(1'b1, 5'd3, 1'b1, 32'hC);
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_data !== 32'hB || bus.out_addr !== 5'd2) begin errors++; $display("FAIL bp_b_out got %h/%0d want b/2", bus.out_data, bus.out_addr); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_a_leaves got %0b want 1", bus.in_ready); end
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hC) begin errors++; $display("FAIL bp_c_out got %0b/%h want 1/c", bus.out_valid, bus.out_data); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_full_rate();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'd4, 1'b1, DATA_W'(i));
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== DATA_W'(i)) begin errors++; $display("FAIL fr_data[%0d] got %0b/%0d want 1/%0d", i, bus.out_valid, bus.out_data, i); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fr_ready[%0d] got %0b want 1", i, bus.in_ready); end
    end
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fr_drain got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd9, 1'b1, 32'hD1);
    tick();
    drive(1'b1, 5'd10, 1'b1, 32'hD2);
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fl_full got %0b want 0", bus.in_ready); end
    drive(1'b1, 5'd11, 1'b1, 32'hD3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fl_ready got %0b want 1", bus.in_ready); end
    checks++; if (bus.out_data !== 32'hD1) begin errors++; $display("FAIL fl_held_data got %h want d1", bus.out_data); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_ghost[%0d] got %0b want 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_x0();
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd0, 1'b1, 32'h55);
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_we !== 1'b0) begin errors++; $display("FAIL x0_bubble got v=%0b we=%0b want v=1 we=0", bus.out_valid, bus.out_we); end
    checks++; if (bus.out_data !== 32'h55) begin errors++; $display("FAIL x0_data got %h want 55", bus.out_data); end
    bus.out_ready = 1'b1;
    drive(1'b1, 5'd6, 1'b0, 32'h66);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_we !== 1'b0 || bus.out_addr !== 5'd6) begin errors++; $display("FAIL we0_bubble got v=%0b we=%0b a=%0d want 1/0/6", bus.out_valid, bus.out_we, bus.out_addr); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL x0_drain got %0b want 0", bus.out_valid); end
  endtask

`ifdef MEM_WB_FWD_EN
  task automatic test_fwd();
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 32'h11);
    tick();
    drive(1'b1, 5'd5, 1'b1, 32'h22);
    bus.fwd_addr = 5'd5;
    #1;
    checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h11) begin errors++; $display("FAIL fwd_main got %0b/%h want 1/11", bus.fwd_hit, bus.fwd_data); end
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h22) begin errors++; $display("FAIL fwd_skid got %0b/%h want 1/22", bus.fwd_hit, bus.fwd_data); end
    bus.fwd_addr = 5'd0;
    #1;
    checks++; if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_x0 got %0b want 0", bus.fwd_hit); end
    bus.fwd_addr = 5'd5;
    flush = 1'b1;
    #1;
    checks++; if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_flush got %0b want 0", bus.fwd_hit); end
    tick();
    flush = 1'b0;
    bus.fwd_addr = 5'd0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    flush  = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'h0);
`ifdef MEM_WB_FWD_EN
    bus.fwd_addr = 5'd0;
`endif
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();

    test_reset();
    test_backpressure();
    test_full_rate();
    test_flush();
    test_x0();
`ifdef MEM_WB_FWD_EN
    test_fwd();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_wb_skid.md
# mem_wb_skid

Parametrised MEM→WB pipeline stage replacing the plain per-cycle register between memory access and write-back. Carries one register-file write request per entry through a two-entry skid buffer with valid/ready handshaking, so write-back back-pressure never forces a combinational ready path into MEM. Also provides synchronous flush and x0 write suppression. An optional forwarding lookup port gives EX/ID bypass access to the held entries.

## Interface
- DATA_W, 32, width of write-back data
- ADDR_W, 5, width of destination register address

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- flush  in  1  synchronous; discard all held entries and the current input
- in_valid  in  1  MEM presents a request
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_addr  in  ADDR_W  destination register
- in_we  in  1  destination exists (write enable)
- in_data  in  DATA_W  write-back data
- out_valid  out  1  request presented to WB
- out_ready  in  1  WB consumes the request
- out_addr  out  ADDR_W  destination register
- out_we  out  1  write enable: main_we & out_valid & (out_addr != 0)
- out_data  out  DATA_W  write-back data
- fwd_addr  in  ADDR_W  lookup address (MEM_WB_FWD_EN only)
- fwd_hit  out  1  lookup matched a held write (MEM_WB_FWD_EN only)
- fwd_data  out  DATA_W  youngest matching data (MEM_WB_FWD_EN only)

## Operation
- Storage: main entry (drives out_*) and skid entry. Each entry holds addr, we, data, and a valid bit.
- Fire conditions:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- States:
  - EMPTY (no entries valid)
  - ONE (main valid)
  - FULL (main and skid valid)
- Transitions:
  - EMPTY: in_fire → main ← in; go to ONE.
  - ONE, in_fire & out_fire → main ← in; stay in ONE.
  - ONE, in_fire only → skid ← in; go to FULL.
  - ONE, out_fire only → go to EMPTY.
  - FULL: in_ready = 0. out_fire → main ← skid; go to ONE.
- flush has highest priority:
  - Next state is EMPTY and both valid bits clear.
  - An in_fire in the same cycle is dropped; upstream treats it as accepted and discarded.
  - An out_fire in the same cycle still counts as consumed by WB.
- Write suppression: an entry with in_we=0 or in_addr=0 still passes through as a valid bubble, with out_we=0.
- Held data: out_addr and out_data keep their last value while out_valid=0. Only reset zeroes them.

## Timing
- Reset (rst=0), asynchronous:
  - out_valid=0, out_we=0, out_addr=0, out_data=0
  - skid and main valid bits = 0, so in_ready=1
- Latency: 1 cycle. in_fire at edge N gives out_valid=1 after edge N.
- Throughput: 1 request per cycle while out_ready=1.
- in_ready is purely registered; there is no combinational path from out_ready to in_ready.
- Order is strictly FIFO; no entry is lost or duplicated except by flush.
- Reset asserted mid-operation clears everything immediately, with no clock required.
- Reset deassertion is synchronised externally.

## Configuration
- MEM_WB_FWD_EN defined:
  - fwd_addr, fwd_hit and fwd_data ports exist. Lookup is combinational.
  - fwd_hit=1 when fwd_addr != 0 and a valid entry has we=1 with a matching addr.
  - fwd_data comes from skid if skid matches (younger), else from main.
  - Both entries are ignored during the cycle flush=1.
- Undefined: the forwarding ports and logic are absent; all other behaviour is identical.

## Test plan
- Reset then stream: assert rst=0 mid-stream → all outputs 0, in_ready=1. Then push addr=3 we=1 data=0xDEADBEEF → out_valid=1 next cycle with the same fields and out_we=1.
- Back-pressure: out_ready=0, push A(addr 1) then B(addr 2) → in_ready=0 after B. Raise out_ready → A then B on consecutive cycles; C is accepted the cycle after A leaves.
- Full-rate: out_ready=1, push 8 back-to-back requests with data 1..8 → out_valid=1 for 8 consecutive cycles, data 1..8 in order, in_ready constant 1.
- Flush: FULL state plus in_valid=1, flush=1 → next cycle out_valid=0, in_ready=1, and none of the three requests appear.
- x0 suppression: push addr=0 we=1 data=0x55 → out_valid=1, out_we=0.
- Forwarding (MEM_WB_FWD_EN): main addr 5 data 0x11, skid addr 5 data 0x22, fwd_addr=5 → fwd_hit=1, fwd_data=0x22. With fwd_addr=0 → fwd_hit=0.
